// File: rtl/mmul_pkg.sv
// Shared constants and state encoding for the Montgomery multiplier result path.
//   MMUL_N   : result width in bits
//   MMUL_W   : external bus word width in bits
//   MMUL_NW  : words per result
//   *_CW     : counter widths for the bit and word counters
package mmul_pkg;

    localparam int MMUL_N  = 256;
    localparam int MMUL_W  = 16;
    localparam int MMUL_NW = MMUL_N / MMUL_W;

    localparam int MMUL_BIT_CW  = $clog2(MMUL_N);
    localparam int MMUL_WORD_CW = $clog2(MMUL_NW);

    typedef logic [1:0] mmul_state_t;

    localparam mmul_state_t ST_IDLE    = 2'd0;
    localparam mmul_state_t ST_COLLECT = 2'd1;
    localparam mmul_state_t ST_UNLOAD  = 2'd2;

endpackage

// File: rtl/mmul_res_unload.sv
// Result unloader: gathers a 256-bit result (bit-serial MSB-first or one
// parallel load) and streams it out as 16-bit words, LS word first, over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin bit-serial collection (IDLE only)
//   bit_in, bit_vld     serial result bit and its qualifier
//   par_ld, par_in      parallel load strobe and value (IDLE only, wins over start)
//   wordout, word_vld   output word and valid
//   word_rdy            downstream ready
//   busy                high while collecting or unloading
//   done                one-cycle pulse after the final word handshake
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for start or par_ld
// COLLECT  | shifting in serial bits until 256 have arrived
// UNLOAD   | presenting reg[15:0]; shift right a word per handshake
module mmul_res_unload
    import mmul_pkg::*;
#(
    parameter int N = MMUL_N,
    parameter int W = MMUL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bit_in,
    input  logic         bit_vld,
    input  logic         par_ld,
    input  logic [N-1:0] par_in,
    output logic [W-1:0] wordout,
    output logic         word_vld,
    input  logic         word_rdy,
    output logic         busy,
    output logic         done
);

    localparam int NW = N / W;

    localparam logic [MMUL_BIT_CW-1:0]  BIT_TC  = MMUL_BIT_CW'(N - 1);
    localparam logic [MMUL_WORD_CW-1:0] WORD_TC = MMUL_WORD_CW'(NW - 1);

    mmul_state_t             state;
    logic [N-1:0]            sreg;
    logic [MMUL_BIT_CW-1:0]  bit_cnt;
    logic [MMUL_WORD_CW-1:0] word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (par_ld) begin
                        sreg     <= par_in;
                        word_cnt <= '0;
                        state    <= ST_UNLOAD;
                    end else if (start) begin
                        sreg    <= '0;
                        bit_cnt <= '0;
                        state   <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bit_vld) begin
                        sreg    <= {sreg[N-2:0], bit_in};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_TC) begin
                            word_cnt <= '0;
                            state    <= ST_UNLOAD;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (word_rdy) begin
                        sreg     <= {{W{1'b0}}, sreg[N-1:W]};
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == WORD_TC) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Valid is a pure function of state, so it cannot drop without a handshake.
    assign word_vld = (state == ST_UNLOAD);
    assign wordout  = word_vld ? sreg[W-1:0] : '0;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mmul_res_unload.sv
module tb_mmul_res_unload;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         bit_in;
    logic         bit_vld;
    logic         par_ld;
    logic [255:0] par_in;
    logic [15:0]  wordout;
    logic         word_vld;
    logic         word_rdy;
    logic         busy;
    logic         done;

    mmul_res_unload dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .par_ld   (par_ld),
        .par_in   (par_in),
        .wordout  (wordout),
        .word_vld (word_vld),
        .word_rdy (word_rdy),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        bit          last;
    } exp_word_t;

    exp_word_t   expq[$];
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    bit          exp_done = 1'b0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_word = '0;
    int          rdy_mode = 0;
    int          lowcnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a result is just 16 words, least significant first.
    task automatic push_words(input logic [255:0] v);
        for (int i = 0; i < 16; i++) begin
            exp_word_t e;
            e.w    = v[i*16 +: 16];
            e.last = (i == 15);
            expq.push_back(e);
        end
    endtask

    // Compare process: every word shown with valid must be the model's next word,
    // held words stay stable, and done follows the final handshake by one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                chk("done", done, exp_done);
                exp_done = 1'b0;
                if (prev_hold) begin
                    chk("hold_vld", word_vld, 1'b1);
                    chk("hold_word", wordout, prev_word);
                end
                if (word_vld) begin
                    if (expq.size() == 0) begin
                        chk("extra_word", 1'b1, 1'b0);
                    end else begin
                        chk("wordout", wordout, expq[0].w);
                        if (word_rdy) begin
                            exp_done = expq[0].last;
                            void'(expq.pop_front());
                        end
                    end
                end
                prev_hold = word_vld && !word_rdy;
                prev_word = wordout;
            end
        end
    end

    // Ready generator: 0 = always ready, 1 = random, 2 = three low cycles per word.
    initial begin
        word_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: word_rdy = 1'b1;
                1: word_rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (!word_vld) begin
                        lowcnt   = 0;
                        word_rdy = 1'b0;
                    end else if (lowcnt < 3) begin
                        lowcnt++;
                        word_rdy = 1'b0;
                    end else begin
                        lowcnt   = 0;
                        word_rdy = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic par_load(input logic [255:0] v, input bit with_start);
        push_words(v);
        par_in = v;
        par_ld = 1'b1;
        start  = with_start;
        @(posedge clk);
        #1;
        par_ld = 1'b0;
        start  = 1'b0;
        par_in = ~v;
    endtask

    task automatic serial_load(input logic [255:0] v, input bit gapped, input bit poke_start);
        push_words(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 255; i >= 0; i--) begin
            if (gapped) begin
                bit_vld = 1'b0;
                bit_in  = 1'($urandom);
                start   = poke_start;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            bit_in  = v[i];
            bit_vld = 1'b1;
            @(posedge clk);
            #1;
            if (i == 1) chk("vld_early", word_vld, 1'b0);
        end
        bit_vld = 1'b0;
        chk("first_vld_latency", word_vld, 1'b1);
        chk("first_word", wordout, {240'd0, v[15:0]});
    endtask

    logic [255:0] pat;
    logic [255:0] v1;
    logic [15:0]  got [16];
    int           n;

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        bit_in  = 1'b0;
        bit_vld = 1'b0;
        par_ld  = 1'b0;
        par_in  = '0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word_vld", word_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wordout", wordout, 16'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Parallel unload, always ready, word i = i.
        for (int i = 0; i < 16; i++) pat[i*16 +: 16] = 16'(i);
        par_load(pat, 1'b0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!busy) break;
            if (n < 16) got[n] = wordout;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'd16);
        chk("done_after_last", done, 1'b1);
        chk("par_word0", got[0], 16'h0000);
        chk("par_word1", got[1], 16'h0001);
        chk("par_word15", got[15], 16'h000F);
        @(posedge clk);
        #1;

        // Serial collect, gap-free: 0x8000...0001.
        v1 = '0;
        v1[255] = 1'b1;
        v1[0]   = 1'b1;
        serial_load(v1, 1'b0, 1'b0);
        chk("ser_word0_lit", wordout, 16'h0001);
        wait_idle();

        // Same data with gapped bits, start pokes in COLLECT and backpressure.
        rdy_mode = 2;
        serial_load(v1, 1'b1, 1'b1);
        repeat (4) begin
            start  = 1'b1;
            par_ld = 1'b1;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        par_ld = 1'b0;
        wait_idle();

        // start and par_ld together: parallel path wins.
        rdy_mode = 1;
        par_load({8{32'hA5C3_1E7F}}, 1'b1);
        wait_idle();

        // Back-to-back: second load in the done cycle.
        par_load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk("b2b_done_seen", done, 1'b1);
        v1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        push_words(v1);
        par_in = v1;
        par_ld = 1'b1;
        @(posedge clk);
        #1;
        par_ld = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        wait_idle();

        // Randomized mix.
        for (int t = 0; t < 10; t++) begin
            rdy_mode = $urandom_range(0, 2);
            v1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) par_load(v1, 1'($urandom));
            else serial_load(v1, 1'($urandom), 1'($urandom));
            wait_idle();
        end

        // Reset mid-UNLOAD after three accepted words.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        par_load(256'h1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_word_vld", word_vld, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wordout", wordout, 16'h0);
        expq.delete();
        exp_done  = 1'b0;
        prev_hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_vld", word_vld, 1'b0);
        chk_en = 1'b1;

        // Full stream after reset.
        par_load(pat, 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
